// File: rtl/interval_meter.sv
// Measures the number of clock cycles between successive rising edges of event_in.
// Supports single-shot and continuous measurement with a saturating count.
module interval_meter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             event_in,
    input  logic             arm,
    output logic [WIDTH-1:0] interval,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state, state_d;
    logic             ev_q;
    logic             ev_edge_c;
    logic [WIDTH-1:0] count, count_d;
    logic             ovf_flag, ovf_flag_d;
    logic [WIDTH-1:0] interval_d;
    logic             overflow_d;
    logic             valid_d;
    logic             busy_d;

    assign ev_edge_c = event_in & ~ev_q;

    // ev_q resets high so a level already high at reset release is not an edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ev_q     <= 1'b1;
            count    <= '0;
            ovf_flag <= 1'b0;
            interval <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            ev_q     <= event_in;
            count    <= count_d;
            ovf_flag <= ovf_flag_d;
            interval <= interval_d;
            overflow <= overflow_d;
            valid    <= valid_d;
            busy     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state;
        count_d    = count;
        ovf_flag_d = ovf_flag;
        interval_d = interval;
        overflow_d = overflow;
        valid_d    = 1'b0;

        case (state)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                // abort wins over a coincident opening edge
                if (!arm) begin
                    state_d = IDLE;
                end else if (ev_edge_c) begin
                    count_d    = WIDTH'(1);
                    ovf_flag_d = 1'b0;
                    state_d    = MEASURE;
                end
            end
            MEASURE: begin
                if (ev_edge_c) begin
                    interval_d = count;
                    overflow_d = ovf_flag;
                    valid_d    = 1'b1;
                    if (arm) begin
                        // closing edge also opens the next measurement
                        count_d    = WIDTH'(1);
                        ovf_flag_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (count == CNT_MAX) begin
                    ovf_flag_d = 1'b1;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_interval_meter.sv
// Directed self-checking bench for interval_meter at WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_interval_meter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             event_in;
    logic             arm;
    logic [WIDTH-1:0] interval;
    logic             valid;
    logic             overflow;
    logic             busy;

    int n_cmp;
    int n_err;
    int n_valid;
    int saved;

    interval_meter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .event_in (event_in),
        .arm      (arm),
        .interval (interval),
        .valid    (valid),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and tally any valid pulse seen after it
    task automatic tick();
        @(posedge clk);
        #1;
        if (valid === 1'b1) n_valid++;
    endtask

    // Hold event_in low for k-1 cycles, then raise it so it is sampled k edges later
    task automatic wait_edge(input int k);
        event_in = 1'b0;
        repeat (k - 1) tick();
        event_in = 1'b1;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input int exp_int, input logic exp_ovf,
                                input logic exp_busy);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_interval"}, 32'(interval), 32'(exp_int));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        n_valid  = 0;
        rst      = 1'b0;
        event_in = 1'b1;
        arm      = 1'b0;

        // Reset with event_in held high
        tick();
        tick();
        check("rst_interval", 32'(interval), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Held-high level across release must not open a measurement
        rst = 1'b1;
        arm = 1'b1;
        repeat (20) tick();
        check("rst_no_valid", 32'(n_valid), 32'd0);
        check("rst_armed_busy", 32'(busy), 32'd1);
        event_in = 1'b0;
        tick();
        event_in = 1'b1;
        tick();
        check("rst_open_no_valid", 32'(valid), 32'd0);
        arm = 1'b0;
        wait_edge(4);
        check_result("late_single", 4, 1'b0, 1'b0);

        // Single-shot, 10 cycles, later edges ignored
        event_in = 1'b0;
        arm = 1'b1;
        tick();
        event_in = 1'b1;
        tick();
        arm = 1'b0;
        saved = n_valid;
        wait_edge(10);
        check_result("single", 10, 1'b0, 1'b0);
        event_in = 1'b0;
        tick();
        check("single_pulse_width", 32'(valid), 32'd0);
        wait_edge(5);
        wait_edge(5);
        check("single_one_valid", 32'(n_valid - saved), 32'd1);
        check("single_idle", 32'(busy), 32'd0);

        // Continuous mode, edges every 7 cycles
        event_in = 1'b0;
        arm = 1'b1;
        tick();
        event_in = 1'b1;
        tick();
        check("cont_open_no_valid", 32'(valid), 32'd0);
        saved = n_valid;
        for (int i = 0; i < 4; i++) begin
            event_in = 1'b0;
            repeat (5) tick();
            check("cont_no_early_valid", 32'(n_valid - saved), 32'(i));
            tick();
            event_in = 1'b1;
            tick();
            check_result("cont", 7, 1'b0, 1'b1);
        end

        // Saturation and recovery in continuous mode, then single-shot close
        wait_edge(300);
        check_result("sat_300", 255, 1'b1, 1'b1);
        wait_edge(20);
        check_result("after_sat_20", 20, 1'b0, 1'b1);
        wait_edge(255);
        check_result("edge_255", 255, 1'b0, 1'b1);
        wait_edge(256);
        check_result("edge_256", 255, 1'b1, 1'b1);
        arm = 1'b0;
        wait_edge(3);
        check_result("cont_to_single", 3, 1'b0, 1'b0);
        event_in = 1'b0;
        tick();

        // Abort in WAIT_FIRST
        saved = n_valid;
        arm = 1'b1;
        tick();
        check("abort_armed_busy", 32'(busy), 32'd1);
        arm = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        repeat (5) tick();
        check("abort_no_valid", 32'(n_valid - saved), 32'd0);

        // Abort beats a coincident opening edge
        arm = 1'b1;
        tick();
        arm = 1'b0;
        event_in = 1'b1;
        tick();
        check("abort_prio_busy", 32'(busy), 32'd0);
        event_in = 1'b0;
        repeat (5) tick();
        check("abort_prio_idle", 32'(busy), 32'd0);
        check("abort_prio_no_valid", 32'(n_valid - saved), 32'd0);

        // Reset 50 cycles into MEASURE
        arm = 1'b1;
        tick();
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        repeat (50) tick();
        rst = 1'b0;
        arm = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_interval", 32'(interval), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        event_in = 1'b1;
        tick();
        event_in = 1'b0;
        repeat (5) tick();
        check("midrst_no_valid", 32'(n_valid - saved), 32'd0);

        // Minimum interval of 2
        arm = 1'b1;
        tick();
        event_in = 1'b1;
        tick();
        saved = n_valid;
        for (int i = 0; i < 6; i++) begin
            event_in = 1'b0;
            tick();
            check("min_gap_no_valid", 32'(valid), 32'd0);
            event_in = 1'b1;
            tick();
            check_result("min", 2, 1'b0, 1'b1);
        end
        arm = 1'b0;
        event_in = 1'b0;
        tick();
        event_in = 1'b1;
        tick();
        check_result("min_single", 2, 1'b0, 1'b0);
        check("min_count", 32'(n_valid - saved), 32'd7);
        event_in = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interval_meter.md
Name: interval_meter

Overview:
- Measures the number of clock cycles between successive rising edges of a single-bit event input, such as the done pulse of the countdown timer.
- It performs the inverse conversion of the timer: the timer turns a count into an interval, and this block turns an interval into a count.
- Used to characterise timer periods on-chip and as the measuring end of timer-driven event links.
- Supports single-shot and continuous measurement, with saturating overflow.

Parameters:
- WIDTH, 8, width of the cycle counter and of the interval result.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-low reset.
- event_in  input  1  event level; each rising edge marks an event.
- arm  input  1  level. Starts a measurement from IDLE; high when a measurement closes means continuous mode.
- interval  output  WIDTH  cycles between the opening and closing edges. Held until the next valid.
- valid  output  1  one-cycle pulse when interval and overflow are updated.
- overflow  output  1  the last reported interval saturated. Held until the next valid.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, interval=0, valid=0, overflow=0, busy=0, count=0, ovf_flag=0.
  - The edge register ev_q resets to 1, so event_in held high across reset release is not an edge.
- Edge detect: edge = event_in & ~ev_q, evaluated combinationally. ev_q <= event_in every cycle. Two edges need at least one low sample between them, so the minimum measurable interval is 2.
- All outputs are registered and update on the clock edge at which the closing edge is sampled.
- valid defaults to 0 every cycle.
- States:
  - IDLE: if arm=1, go to WAIT_FIRST. An edge in IDLE is ignored, even when it coincides with arm rising.
  - WAIT_FIRST:
    - If arm=0, go to IDLE (abort). Abort has priority over a coincident edge.
    - Else, on an edge: count<=1, ovf_flag<=0, go to MEASURE.
  - MEASURE:
    - On an edge: interval<=count, overflow<=ovf_flag, valid<=1.
      - If arm=1: count<=1, ovf_flag<=0, stay in MEASURE (continuous; the closing edge also opens the next measurement).
      - If arm=0: go to IDLE (single-shot complete).
    - With no edge:
      - If count == 2^WIDTH-1: count holds and ovf_flag<=1.
      - Else count<=count+1.
    - Dropping arm in MEASURE does not abort. It only selects single-shot when the closing edge arrives.
- Arithmetic:
  - interval equals t1-t0, where t0 and t1 are the clock edges at which the opening and closing edges were sampled.
  - Saturation reports 2^WIDTH-1 with overflow=1. There is no wrap-around.
- busy is registered and reflects the next state. It falls on the same edge that valid rises when single-shot completes.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no valid issued.

Test Plan:
- Reset, with event_in=1 and rst=0 for 2 cycles, then released -> interval=0, valid=0, overflow=0, busy=0; no valid during the following 20 cycles.
- Single-shot: arm=1 for 1 cycle, edges 10 cycles apart, arm=0 before the second edge -> a single one-cycle valid with interval=10 and overflow=0; busy falls on the same edge; later edges ignored.
- Continuous: arm held 1, event_in driven by the timer done with edges every 7 cycles -> valid every 7 cycles, interval=7 each time; the first valid comes 7 cycles after the first edge.
- Overflow at WIDTH=8:
  - Edges 300 cycles apart -> interval=255, overflow=1.
  - A following 20-cycle gap in continuous mode -> interval=20, overflow=0.
- Abort and mid-operation reset:
  - arm dropped in WAIT_FIRST before any edge -> IDLE, busy=0, no valid.
  - rst=0 for 1 cycle, 50 cycles into MEASURE -> IDLE, all outputs 0, no valid from the interrupted measurement.
- Minimum interval: event_in toggling every cycle (edges 2 apart) with arm=1 -> interval=2 on every valid, valid every 2 cycles.
